// File: rtl/grabbable_object_ctrl.sv
// Grabbable object slot: holds one sprite, attaches it to the hook on contact,
// follows the hook tip once per frame and emits a score when the hook is reeled in.
module grabbable_object_ctrl #(
  parameter int OBJECT_WIDTH  = 32,
  parameter int OBJECT_HEIGHT = 32,
  parameter int SCREEN_H      = 480
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        loadValid,
  input  logic [10:0] loadX,
  input  logic [10:0] loadY,
  input  logic [3:0]  loadType,
  input  logic        collision,
  input  logic [10:0] hookTipX,
  input  logic [10:0] hookTipY,
  input  logic        hookRetracted,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic [3:0]  objectType,
  output logic        loadReady,
  output logic        attached,
  output logic        scoreValid,
  output logic [9:0]  scoreValue,
  output logic [2:0]  hookWeight
);

  localparam logic [10:0] HALF_W = 11'(OBJECT_WIDTH / 2);
  localparam logic [10:0] Y_MAX  = 11'(SCREEN_H - OBJECT_HEIGHT);

  typedef enum logic [1:0] {EMPTY, RESTING, ATTACHED, COLLECT} state_t;

  state_t      state, state_nxt;
  logic        hit_latch, hit_nxt;
  logic [10:0] pos_x_nxt, pos_y_nxt;
  logic [3:0]  type_nxt;

  function automatic logic [10:0] sat_x(input logic [10:0] tip);
    return (tip < HALF_W) ? 11'd0 : tip - HALF_W;
  endfunction

  function automatic logic [10:0] sat_y(input logic [10:0] tip);
    return (tip > Y_MAX) ? Y_MAX : tip;
  endfunction

  function automatic logic [9:0] score_of(input logic [3:0] kind);
    case (kind)
      4'd1:    return 10'd50;
      4'd2:    return 10'd100;
      4'd3:    return 10'd500;
      4'd4:    return 10'd20;
      default: return 10'd0;
    endcase
  endfunction

  function automatic logic [2:0] weight_of(input logic [3:0] kind);
    case (kind)
      4'd1:    return 3'd2;
      4'd2:    return 3'd3;
      4'd3:    return 3'd4;
      4'd4:    return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    hit_nxt   = hit_latch;
    pos_x_nxt = topLeftX;
    pos_y_nxt = topLeftY;
    type_nxt  = objectType;
    case (state)
      EMPTY: begin
        hit_nxt = 1'b0;
        if (loadValid && loadType >= 4'd1 && loadType <= 4'd4) begin
          state_nxt = RESTING;
          pos_x_nxt = loadX;
          pos_y_nxt = loadY;
          type_nxt  = loadType;
        end
      end
      RESTING: begin
        // A hit anywhere in the frame is only acted on at the frame boundary.
        if (startOfFrame) begin
          hit_nxt = 1'b0;
          if (hit_latch || collision) state_nxt = ATTACHED;
        end else if (collision) begin
          hit_nxt = 1'b1;
        end
      end
      ATTACHED: begin
        hit_nxt = 1'b0;
        if (startOfFrame) begin
          if (hookRetracted) begin
            state_nxt = COLLECT;
          end else begin
            pos_x_nxt = sat_x(hookTipX);
            pos_y_nxt = sat_y(hookTipY);
          end
        end
      end
      COLLECT: begin
        state_nxt = EMPTY;
        hit_nxt   = 1'b0;
        pos_x_nxt = 11'd0;
        pos_y_nxt = 11'd0;
        type_nxt  = 4'd0;
      end
      default: begin
        state_nxt = EMPTY;
        hit_nxt   = 1'b0;
        pos_x_nxt = 11'd0;
        pos_y_nxt = 11'd0;
        type_nxt  = 4'd0;
      end
    endcase
  end

  // Status outputs are decoded from the next state so every port is a flop.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state      <= EMPTY;
      hit_latch  <= 1'b0;
      topLeftX   <= 11'd0;
      topLeftY   <= 11'd0;
      objectType <= 4'd0;
      loadReady  <= 1'b1;
      attached   <= 1'b0;
      scoreValid <= 1'b0;
      scoreValue <= 10'd0;
      hookWeight <= 3'd0;
    end else begin
      state      <= state_nxt;
      hit_latch  <= hit_nxt;
      topLeftX   <= pos_x_nxt;
      topLeftY   <= pos_y_nxt;
      objectType <= type_nxt;
      loadReady  <= (state_nxt == EMPTY);
      attached   <= (state_nxt == ATTACHED);
      scoreValid <= (state_nxt == COLLECT);
      scoreValue <= (state_nxt == COLLECT) ? score_of(type_nxt) : 10'd0;
      hookWeight <= (state_nxt == ATTACHED) ? weight_of(type_nxt) : 3'd0;
    end
  end

endmodule

// File: tb/tb_grabbable_object_ctrl.sv
// Scoreboard bench for grabbable_object_ctrl: directed scenarios then random
// traffic, compared every cycle against a rule-level reference model.
module tb_grabbable_object_ctrl;

  localparam int HALF_W = 16;
  localparam int Y_MAX  = 480 - 32;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        loadValid = 1'b0;
  logic [10:0] loadX = '0, loadY = '0;
  logic [3:0]  loadType = '0;
  logic        collision = 1'b0;
  logic [10:0] hookTipX = '0, hookTipY = '0;
  logic        hookRetracted = 1'b0;
  logic [10:0] topLeftX, topLeftY;
  logic [3:0]  objectType;
  logic        loadReady, attached, scoreValid;
  logic [9:0]  scoreValue;
  logic [2:0]  hookWeight;

  grabbable_object_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .loadValid(loadValid), .loadX(loadX), .loadY(loadY), .loadType(loadType),
    .collision(collision), .hookTipX(hookTipX), .hookTipY(hookTipY),
    .hookRetracted(hookRetracted), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .objectType(objectType), .loadReady(loadReady), .attached(attached),
    .scoreValid(scoreValid), .scoreValue(scoreValue), .hookWeight(hookWeight)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int x, y, t;
    bit lr, at, sv;
    int sval, hw;
  } exp_t;

  typedef struct {
    int due;
    int v;
  } score_t;

  exp_t   exp_q[$];
  score_t score_q[$];
  int     pcount = 0;
  int     checks = 0;
  int     errors = 0;

  int score_tbl[16] = '{0, 50, 100, 500, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int weight_tbl[16] = '{0, 2, 3, 4, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  // Reference model: what the object is doing, not how the RTL encodes it.
  bit m_present, m_on_hook, m_collecting, m_hit;
  int m_x, m_y, m_t;

  always @(posedge clk) pcount <= pcount + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, pcount);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    score_t s;
    while (exp_q.size() > 0 && exp_q[0].due <= pcount) begin
      e = exp_q.pop_front();
      check("topLeftX", int'(topLeftX), e.x);
      check("topLeftY", int'(topLeftY), e.y);
      check("objectType", int'(objectType), e.t);
      check("loadReady", int'(loadReady), int'(e.lr));
      check("attached", int'(attached), int'(e.at));
      check("scoreValid", int'(scoreValid), int'(e.sv));
      check("scoreValue", int'(scoreValue), e.sval);
      check("hookWeight", int'(hookWeight), e.hw);
    end
    if (scoreValid === 1'b1) begin
      if (score_q.size() == 0) begin
        check("unexpected_score_pulse", 1, 0);
      end else begin
        s = score_q.pop_front();
        check("score_event_cycle", pcount, s.due);
        check("score_event_value", int'(scoreValue), s.v);
      end
    end
  end

  task automatic drive(input bit rn, input bit sof, input bit lv, input int lx, input int ly,
                       input int lt, input bit col, input int tx, input int ty, input bit ret);
    exp_t e;
    score_t s;
    @(negedge clk);
    resetN = rn; startOfFrame = sof; loadValid = lv;
    loadX = 11'(lx); loadY = 11'(ly); loadType = 4'(lt);
    collision = col; hookTipX = 11'(tx); hookTipY = 11'(ty); hookRetracted = ret;

    if (!rn) begin
      m_present = 0; m_on_hook = 0; m_collecting = 0; m_hit = 0;
      m_x = 0; m_y = 0; m_t = 0;
    end else if (m_collecting) begin
      m_collecting = 0; m_present = 0; m_x = 0; m_y = 0; m_t = 0;
    end else if (!m_present) begin
      if (lv && lt >= 1 && lt <= 4) begin
        m_present = 1; m_x = lx; m_y = ly; m_t = lt;
      end
    end else if (!m_on_hook) begin
      if (sof) begin
        if (m_hit || col) m_on_hook = 1;
        m_hit = 0;
      end else if (col) begin
        m_hit = 1;
      end
    end else if (sof) begin
      if (ret) begin
        m_on_hook = 0; m_collecting = 1;
      end else begin
        m_x = (tx >= HALF_W) ? tx - HALF_W : 0;
        m_y = (ty > Y_MAX) ? Y_MAX : ty;
      end
    end

    e.due = pcount + 1;
    e.x = m_x; e.y = m_y; e.t = m_t;
    e.lr = !m_present; e.at = m_on_hook; e.sv = m_collecting;
    e.sval = m_collecting ? score_tbl[m_t] : 0;
    e.hw = m_on_hook ? weight_tbl[m_t] : 0;
    exp_q.push_back(e);
    if (m_collecting) begin
      s.due = pcount + 1;
      s.v = score_tbl[m_t];
      score_q.push_back(s);
    end
  endtask

  task automatic idle(input int n, input int tx, input int ty);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, tx, ty, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2, 0, 0);
    // Invalid loads
    drive(1, 0, 1, 10, 20, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 10, 20, 7, 0, 0, 0, 0);
    drive(1, 0, 1, 10, 20, 15, 0, 0, 0, 0);
    // Valid load, then a second load that must be ignored
    drive(1, 0, 1, 100, 200, 3, 0, 0, 0, 0);
    drive(1, 0, 1, 7, 9, 1, 0, 0, 0, 0);
    // Collision mid-frame, grab at next frame start, follow the tip
    idle(2, 300, 250);
    drive(1, 0, 0, 0, 0, 0, 1, 300, 250, 0);
    idle(3, 300, 250);
    drive(1, 1, 0, 0, 0, 0, 0, 300, 250, 0);
    idle(3, 300, 250);
    drive(1, 1, 0, 0, 0, 0, 0, 300, 250, 0);
    idle(4, 600, 100);
    // Clamp at both edges
    drive(1, 1, 0, 0, 0, 0, 0, 5, 470, 0);
    idle(2, 5, 470);
    drive(1, 1, 0, 0, 0, 0, 0, 16, 448, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 15, 449, 0);
    // Collect type 3
    drive(1, 1, 0, 0, 0, 0, 1, 40, 40, 1);
    idle(3, 0, 0);
    // Load coincident with frame start, then same-cycle collision grab, collect type 4
    drive(1, 1, 1, 50, 60, 4, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 1, 80, 90, 0);
    idle(2, 80, 90);
    drive(1, 1, 0, 0, 0, 0, 0, 80, 90, 1);
    idle(3, 0, 0);
    // Stale hit must be dropped at frame start without collision
    drive(1, 0, 1, 1, 2, 2, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Grab and reset while attached
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 200, 200, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 200, 200, 0);
    drive(0, 1, 1, 5, 5, 1, 1, 200, 200, 1);
    idle(3, 0, 0);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
            int'($urandom_range(0, 7)),
            ($urandom_range(0, 4) == 0),
            int'($urandom_range(0, 2047)), int'($urandom_range(0, 600)),
            ($urandom_range(0, 2) == 0));
    end
    idle(2, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("expect_queue_drained", exp_q.size(), 0);
    check("score_queue_drained", score_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/grabbable_object_ctrl.md
GRABBABLE_OBJECT_CTRL -- requirements
Module: grabbable_object_ctrl

Interface
REQ-001 Parameter OBJECT_WIDTH, 32, sprite width in pixels; the hang point is OBJECT_WIDTH/2.
REQ-002 Parameter OBJECT_HEIGHT, 32, sprite height in pixels.
REQ-003 Parameter SCREEN_H, 480, visible lines; used for the Y clamp.
REQ-004 clk  in  1  system clock; all logic on its rising edge.
REQ-005 resetN  in  1  reset, synchronous and active-low.
REQ-006 startOfFrame  in  1  one-cycle pulse, once per video frame.
REQ-007 loadValid  in  1  request to place a new object; sampled every cycle.
REQ-008 loadX, loadY  in  11 each  top-left placement coordinates.
REQ-009 loadType  in  4  object type: 0 FILLER, 1 VALUABLE_1, 2 VALUABLE_2, 3 VALUABLE_3, 4 ROCK_1.
REQ-010 collision  in  1  pixel-level overlap of the hook and object draw requests.
REQ-011 hookTipX, hookTipY  in  11 each  current hook tip coordinates.
REQ-012 hookRetracted  in  1  level; high while the hook is at the rope origin.
REQ-013 topLeftX, topLeftY  out  11 each  sprite position driven to the sprite renderer.
REQ-014 objectType  out  4  sprite type driven to the renderer; 0 means nothing is drawn.
REQ-015 loadReady  out  1  high while the slot is EMPTY.
REQ-016 attached  out  1  high while the object is on the hook.
REQ-017 scoreValid  out  1  one-cycle pulse when the object is collected.
REQ-018 scoreValue  out  10  points for the collected object; valid with scoreValid.
REQ-019 hookWeight  out  3  reel slow-down factor for the hook controller.

Function
REQ-020 States: EMPTY, RESTING, ATTACHED, COLLECT; every output SHALL be driven from a register.
REQ-021 EMPTY with loadValid=1 and loadType in 1..4: capture loadX, loadY and loadType, then enter RESTING; the new values appear on the outputs one cycle later.
REQ-022 EMPTY with loadValid=1 and loadType 0 or 5..15: ignore the request and stay EMPTY.
REQ-023 loadValid in RESTING, ATTACHED or COLLECT: ignore; no state or position change.
REQ-024 EMPTY with loadValid and startOfFrame in the same cycle: the load is taken.
REQ-025 RESTING: any cycle with collision=1 sets hitLatch; position is held.
REQ-026 RESTING at startOfFrame with hitLatch=1, or with collision=1 in that same cycle: enter ATTACHED; hitLatch cleared.
REQ-027 hitLatch SHALL clear at every startOfFrame.
REQ-028 collision in EMPTY, ATTACHED or COLLECT: ignored, not latched.
REQ-029 ATTACHED with startOfFrame=1 and hookRetracted=0: update position.
  - topLeftX = hookTipX - OBJECT_WIDTH/2, saturated at 0.
  - topLeftY = hookTipY, saturated at SCREEN_H - OBJECT_HEIGHT.
REQ-030 ATTACHED: position SHALL stay constant between startOfFrame pulses (no tearing mid-frame).
REQ-031 ATTACHED with startOfFrame=1 and hookRetracted=1: enter COLLECT; no position update that cycle.
REQ-032 COLLECT: lasts exactly one cycle.
  - scoreValid=1, scoreValue per REQ-033, objectType still the held type.
  - Next state EMPTY, with objectType=0 and position 0.
REQ-033 Score table: type 1 -> 50, 2 -> 100, 3 -> 500, 4 -> 20; scoreValue is 0 whenever scoreValid=0.
REQ-034 hookWeight in ATTACHED: type 1 -> 2, 2 -> 3, 3 -> 4, 4 -> 6; 0 in every other state.
REQ-035 loadReady = (state==EMPTY); attached = (state==ATTACHED).

Reset
REQ-036 resetN=0 at a clock edge SHALL set, on the next cycle:
  - state EMPTY; topLeftX/Y 0; objectType 0; hitLatch 0.
  - scoreValid 0; scoreValue 0; hookWeight 0; attached 0; loadReady 1.
REQ-037 Reset in ATTACHED or COLLECT SHALL discard the object with no scoreValid pulse; reset dominates all other inputs.

Verification
REQ-038 Load: loadValid, (100,200), type 3 -> next cycle objectType=3, topLeft=(100,200), loadReady=0.
REQ-039 Invalid load: loadType=0, then loadType=7 -> stays EMPTY, objectType=0, loadReady=1.
REQ-040 Grab: collision pulse mid-frame, then startOfFrame with hookTip=(300,250) -> attached=1 and hookWeight=4 (type 3); at the next startOfFrame topLeft=(284,250).
REQ-041 Clamp: attached, hookTip=(5,470) at startOfFrame -> topLeft=(0,448).
REQ-042 Collect: attached type 4, hookRetracted=1 at startOfFrame -> one-cycle scoreValid with scoreValue=20, then objectType=0 and loadReady=1.
REQ-043 Reset mid-ATTACHED: resetN=0 for one cycle -> all outputs at reset values, no scoreValid ever asserted.
